// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared constants and digit decode table for the seven-segment scan driver
// Purpose: segment constants, digit count, segment bit positions and the
//          4-bit value to active-low segment decode used by the scan driver.
// Ports:   none (package).
package ssd_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hFD;

  // Bit positions within pattern = {a,b,c,d,e,f,g,dp}
  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  // Active-low segments; the dp bit is always returned off (1).
  function automatic logic [7:0] seg_lookup(input logic [3:0] value);
    logic [7:0] seg;
    case (value)
      4'd0:    seg = 8'h03;
      4'd1:    seg = 8'h9F;
      4'd2:    seg = 8'h25;
      4'd3:    seg = 8'h0D;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h49;
      4'd6:    seg = 8'h41;
      4'd7:    seg = 8'h1F;
      4'd8:    seg = 8'h01;
      4'd9:    seg = 8'h09;
      4'd15:   seg = SEG_DASH;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/ssd_seg_decode.sv
// rtl/ssd_seg_decode.sv - combinational 4-bit value to active-low seven-segment decode
// Purpose: decodes one digit value into {a,b,c,d,e,f,g,dp}, dp always off.
// Ports:   value_i  4-bit digit value
//          seg_o    8-bit active-low segment pattern
module ssd_seg_decode
  import ssd_pkg::*;
(
  input  logic [3:0] value_i,
  output logic [7:0] seg_o
);

  assign seg_o = seg_lookup(value_i);

endmodule

// File: rtl/ssd_scan_driver.sv
// rtl/ssd_scan_driver.sv - four-digit time-multiplexed seven-segment scan driver
// Purpose: scans four digits at SCAN_DIV cycles each, captures inputs once per
//          frame, applies leading-zero blanking, decimal points and blink.
// Ports:   clk       system clock
//          rst       synchronous active-high reset
//          digits    {d3,d2,d1,d0} 4-bit values, d0 rightmost
//          dp        per-digit decimal point enable
//          blank_lz  leading-zero blanking enable
//          blink     per-digit blink enable
//          position  active-low one-hot digit enable
//          pattern   active-low segments {a,b,c,d,e,f,g,dp}
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int SCAN_DIV     = 50_000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic [3:0]  dp,
  input  logic        blank_lz,
  input  logic [3:0]  blink,
  output logic [3:0]  position,
  output logic [7:0]  pattern
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       idx_q, idx_d, idx_next;
  logic [15:0]      digits_q, digits_d;
  logic [3:0]       dp_q, dp_d, blink_q, blink_d;
  logic             blank_lz_q, blank_lz_d;
  logic [FRM_W-1:0] frm_q, frm_d;
  logic             phase_q, phase_d;
  logic [3:0]       position_q, position_d;
  logic [7:0]       pattern_q, pattern_d;

  logic        tick, frame;
  logic [15:0] eff_digits;
  logic [3:0]  eff_dp, eff_blink;
  logic        eff_lz;
  logic [3:0]  cur_val;
  logic [7:0]  cur_seg;
  logic        lz_blank;

  assign tick     = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
  assign frame    = tick && (idx_q == 2'd3);
  assign idx_next = idx_q + 2'd1;

  // On the frame boundary digit 0 must already see the freshly captured inputs.
  assign eff_digits = frame ? digits   : digits_q;
  assign eff_dp     = frame ? dp       : dp_q;
  assign eff_blink  = frame ? blink    : blink_q;
  assign eff_lz     = frame ? blank_lz : blank_lz_q;

  assign cur_val = eff_digits[{idx_next, 2'b00} +: 4];

  // A digit is a leading zero when it and every digit above it are zero.
  assign lz_blank = eff_lz && (idx_next != 2'd0) &&
                    ((eff_digits >> {idx_next, 2'b00}) == 16'h0000);

  ssd_seg_decode u_decode (
    .value_i (cur_val),
    .seg_o   (cur_seg)
  );

  always_comb begin
    div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
    idx_d      = tick ? idx_next : idx_q;
    digits_d   = frame ? digits   : digits_q;
    dp_d       = frame ? dp       : dp_q;
    blink_d    = frame ? blink    : blink_q;
    blank_lz_d = frame ? blank_lz : blank_lz_q;

    frm_d   = frm_q;
    phase_d = phase_q;
    if (frame) begin
      if (frm_q == FRM_W'(BLINK_FRAMES - 1)) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end

    position_d = position_q;
    pattern_d  = pattern_q;
    if (tick) begin
      position_d = ~(4'b0001 << idx_next);
      pattern_d  = (lz_blank ? SEG_BLANK : cur_seg) & {7'h7F, ~eff_dp[idx_next]};
      // Blink uses the registered phase, so the phase change lands on the
      // digit-0 update of the following frame.
      if (phase_q && eff_blink[idx_next]) begin
        pattern_d = SEG_BLANK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q  <= '0;
      idx_q      <= 2'd3;
      digits_q   <= '0;
      dp_q       <= '0;
      blink_q    <= '0;
      blank_lz_q <= 1'b0;
      frm_q      <= '0;
      phase_q    <= 1'b0;
      position_q <= 4'b1111;
      pattern_q  <= SEG_BLANK;
    end else begin
      div_cnt_q  <= div_cnt_d;
      idx_q      <= idx_d;
      digits_q   <= digits_d;
      dp_q       <= dp_d;
      blink_q    <= blink_d;
      blank_lz_q <= blank_lz_d;
      frm_q      <= frm_d;
      phase_q    <= phase_d;
      position_q <= position_d;
      pattern_q  <= pattern_d;
    end
  end

  assign position = position_q;
  assign pattern  = pattern_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb/tb_ssd_scan_driver.sv - self-checking bench for ssd_scan_driver
module tb_ssd_scan_driver;

  localparam int SD = 4;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits = 16'h0000;
  logic [3:0]  dp = 4'h0;
  logic        blank_lz = 1'b0;
  logic [3:0]  blink = 4'h0;
  logic [3:0]  position;
  logic [7:0]  pattern;

  int checks = 0;
  int errors = 0;

  logic [7:0] seg_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                               8'h01, 8'h09, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFD};
  logic [3:0] pos_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // Reference model state: cycles since reset release, frame boundaries seen.
  int          m_n = 0;
  int          m_nb = 0;
  int          m_dig = -1;
  logic [15:0] m_dg = 16'h0;
  logic [3:0]  m_dp = 4'h0, m_bl = 4'h0;
  logic        m_lz = 1'b0;
  logic [3:0]  exp_pos = 4'hF;
  logic [7:0]  exp_pat = 8'hFF;

  ssd_scan_driver #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk      (clk),
    .rst      (rst),
    .digits   (digits),
    .dp       (dp),
    .blank_lz (blank_lz),
    .blink    (blink),
    .position (position),
    .pattern  (pattern)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] expect_pat(int dig, logic [15:0] dg, logic [3:0] dpv,
                                            logic lz, logic [3:0] bl, int phase);
    logic [3:0]  v;
    logic [15:0] upper;
    if (phase == 1 && bl[dig]) return 8'hFF;
    v = dg[4*dig +: 4];
    upper = dg >> (4*dig);
    if (lz && dig > 0 && upper == 16'h0) return {7'h7F, ~dpv[dig]};
    return seg_tab[v] & {7'h7F, ~dpv[dig]};
  endfunction

  task automatic model_edge();
    int ticks, ph;
    if (rst) begin
      m_n = 0; m_nb = 0; m_dig = -1;
      m_dg = '0; m_dp = '0; m_bl = '0; m_lz = 1'b0;
      exp_pos = 4'hF; exp_pat = 8'hFF;
    end else begin
      m_n++;
      if (m_n % SD == 0) begin
        ticks = m_n / SD;
        m_dig = (ticks - 1) % 4;
        if (m_dig == 0) begin
          m_dg = digits; m_dp = dp; m_bl = blink; m_lz = blank_lz;
          ph = (m_nb / BF) % 2;
          m_nb++;
        end else begin
          ph = (m_nb / BF) % 2;
        end
        exp_pos = pos_tab[m_dig];
        exp_pat = expect_pat(m_dig, m_dg, m_dp, m_lz, m_bl, ph);
      end
    end
  endtask

  task automatic check8(string tag, logic [7:0] got, logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, m_n);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check8("position", {4'h0, position}, {4'h0, exp_pos});
    check8("pattern", pattern, exp_pat);
  endtask

  task automatic wait_dig(int d);
    int guard = 0;
    while (m_dig != d && guard < 100) begin
      step();
      guard++;
    end
    checks++;
    assert (guard < 100) else begin
      errors++;
      $error("FAIL wait_dig: digit %0d not reached, at %0d", d, m_dig);
    end
  endtask

  task automatic next_frame();
    wait_dig(3);
    wait_dig(0);
  endtask

  initial begin
    // Reset release
    rst = 1'b1; digits = 16'h1234;
    repeat (3) step();
    check8("rst_pos", {4'h0, position}, 8'h0F);
    check8("rst_pat", pattern, 8'hFF);
    rst = 1'b0;
    repeat (3) step();
    check8("pre_tick_pat", pattern, 8'hFF);
    step();
    check8("first_pos", {4'h0, position}, 8'h0E);
    check8("first_pat", pattern, 8'h99);
    repeat (4) step();
    check8("d1_pat", pattern, 8'h0D);
    repeat (24) step();

    // Leading-zero blanking
    blank_lz = 1'b1; digits = 16'h0050;
    next_frame();
    wait_dig(1); check8("lz_d1", pattern, 8'h49);
    wait_dig(2); check8("lz_d2", pattern, 8'hFF);
    wait_dig(3); check8("lz_d3", pattern, 8'hFF);
    wait_dig(0); check8("lz_d0", pattern, 8'h03);
    digits = 16'h0000;
    next_frame();
    check8("lz0_d0", pattern, 8'h03);
    wait_dig(1); check8("lz0_d1", pattern, 8'hFF);
    dp = 4'b0100; digits = 16'h0050;
    next_frame();
    wait_dig(2); check8("lz_dp_d2", pattern, 8'hFE);

    // No tearing
    dp = 4'h0; blank_lz = 1'b0; digits = 16'h1234;
    next_frame();
    wait_dig(1);
    digits = 16'h5678;
    wait_dig(2); check8("tear_d2", pattern, 8'h25);
    wait_dig(3); check8("tear_d3", pattern, 8'h9F);
    wait_dig(0);
    wait_dig(1); check8("tear_new_d1", pattern, 8'h1F);

    // Blink
    blink = 4'b0001; digits = 16'h0008;
    repeat (12 * 4 * SD) step();

    // Reset mid-scan
    blink = 4'h0; digits = 16'h1234;
    next_frame();
    wait_dig(2);
    rst = 1'b1;
    step();
    check8("mid_rst_pos", {4'h0, position}, 8'h0F);
    check8("mid_rst_pat", pattern, 8'hFF);
    rst = 1'b0;
    repeat (4) step();
    check8("restart_pos", {4'h0, position}, 8'h0E);
    check8("restart_pat", pattern, 8'h99);

    // Out-of-range values
    digits = 16'hFA00;
    next_frame();
    wait_dig(2); check8("oor_d2", pattern, 8'hFF);
    wait_dig(3); check8("oor_d3", pattern, 8'hFD);

    // Randomized inputs with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        digits   = 16'($urandom);
        dp       = 4'($urandom);
        blink    = 4'($urandom);
        blank_lz = 1'($urandom);
        if ($urandom_range(0, 2) == 0) digits = digits & 16'h00FF;
      end
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
